// File: rtl/fftb_fifo_drain_scheduler.sv
// Avalon-MM read master: drains NUM_SRC FFT-bin FIFOs round-robin in BLOCK_LEN-word blocks into Avalon-ST packets.
// Latency: one cycle from src_read to the word entering the 2-entry output buffer; the head word is presented combinationally.
// Backpressure: reads are throttled so buffer occupancy plus in-flight reads never exceeds 2; a stalled sink pauses the source reads.
//
// Ports: clock/reset_n (async, active-low); enable starts new blocks; src_* is the per-source
// Avalon-MM read side (latency 1, waitrequest = FIFO empty); out_* is the Avalon-ST side
// (data/valid/ready/sop/eop/channel); busy flags an open block; block_done pulses on eop acceptance.
// Optional macro FFTB_DRAIN_TIMEOUT_EN adds TIMEOUT_CYC and err_timeout: a starved block is zero-padded to full length.
module fftb_fifo_drain_scheduler #(
    parameter int NUM_SRC   = 2,
    parameter int BLOCK_LEN = 64,
    parameter int DATA_W    = 32
`ifdef FFTB_DRAIN_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      enable,
    output logic [NUM_SRC-1:0]        src_address,
    output logic [NUM_SRC-1:0]        src_read,
    input  logic [NUM_SRC*DATA_W-1:0] src_readdata,
    input  logic [NUM_SRC-1:0]        src_waitrequest,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic [2:0]                out_channel,
    output logic                      busy,
`ifdef FFTB_DRAIN_TIMEOUT_EN
    output logic                      err_timeout,
`endif
    output logic                      block_done
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W = $clog2(BLOCK_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_BURST, S_DRAIN} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
        logic [2:0]        ch;
    } entry_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   ptr, grant;
    logic [CNT_W-1:0]   issued, delivered;
    logic               inflight;
    entry_t             buf_mem [2];
    logic               wr_sel, rd_sel;
    logic [1:0]         occ;
    logic               timed_out;

    // Round-robin scan, starting one past the last granted source.
    logic               sel_found;
    logic [PTR_W-1:0]   sel_idx;
    logic [PTR_W-1:0]   cand;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = PTR_W'((int'(ptr) + k) % NUM_SRC);
            if (!sel_found && !src_waitrequest[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    logic               gnt_wait;
    logic               block_left;
    logic               room;
    logic               issue;
    logic               pad;
    logic               push;
    logic               pop;
    logic               grab;
    entry_t             push_entry;

    assign gnt_wait   = src_waitrequest[grant];
    assign block_left = (issued < CNT_W'(BLOCK_LEN));
    // Occupancy counts only the current contents; a same-cycle pop is not credited.
    assign room       = (occ == 2'd0) || ((occ == 2'd1) && !inflight);
    assign issue      = (state == S_BURST) && !gnt_wait && block_left && room && !timed_out;
    // Zero padding after a timeout waits for any outstanding read so only one push happens per cycle.
    assign pad        = (state == S_BURST) && timed_out && block_left && !inflight && (occ != 2'd2);
    assign push       = inflight | pad;
    assign pop        = out_valid & out_ready;
    assign grab       = (state == S_SELECT) && enable && sel_found;

    always_comb begin
        push_entry      = '0;
        push_entry.data = inflight ? src_readdata[int'(grant)*DATA_W +: DATA_W] : '0;
        push_entry.sop  = (delivered == '0);
        push_entry.eop  = (delivered == CNT_W'(BLOCK_LEN - 1));
        push_entry.ch   = 3'(grant);
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (enable) state_nxt = S_SELECT;
            S_SELECT: begin
                if (!enable)        state_nxt = S_IDLE;
                else if (sel_found) state_nxt = S_BURST;
            end
            S_BURST:  if (issued == CNT_W'(BLOCK_LEN)) state_nxt = S_DRAIN;
            S_DRAIN:  if ((occ == 2'd0) && !inflight) state_nxt = enable ? S_SELECT : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        src_address = '0;
        src_read    = issue ? (NUM_SRC'(1) << grant) : '0;
        out_valid   = (occ != 2'd0);
        out_data    = buf_mem[rd_sel].data;
        out_sop     = buf_mem[rd_sel].sop;
        out_eop     = buf_mem[rd_sel].eop;
        out_channel = buf_mem[rd_sel].ch;
        block_done  = out_valid && out_ready && buf_mem[rd_sel].eop;
        busy        = (state == S_BURST) || (occ != 2'd0) || inflight;
    end

    // Grant, counters and output buffer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr        <= PTR_W'(NUM_SRC - 1);
            grant      <= '0;
            issued     <= '0;
            delivered  <= '0;
            inflight   <= 1'b0;
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            wr_sel     <= 1'b0;
            rd_sel     <= 1'b0;
            occ        <= 2'd0;
        end else begin
            inflight <= issue;
            if (grab) begin
                grant     <= sel_idx;
                ptr       <= sel_idx;
                issued    <= '0;
                delivered <= '0;
            end else begin
                if (issue || pad) issued    <= issued + 1'b1;
                if (push)         delivered <= delivered + 1'b1;
            end
            if (push) begin
                buf_mem[wr_sel] <= push_entry;
                wr_sel          <= ~wr_sel;
            end
            if (pop) rd_sel <= ~rd_sel;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

`ifdef FFTB_DRAIN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;

    // Counts consecutive starved cycles on the granted source; cleared by any read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt      <= '0;
            timed_out   <= 1'b0;
            err_timeout <= 1'b0;
        end else if (state != S_BURST) begin
            to_cnt    <= '0;
            timed_out <= 1'b0;
        end else if (issue) begin
            to_cnt <= '0;
        end else if (gnt_wait && block_left && !timed_out) begin
            to_cnt <= to_cnt + 1'b1;
            if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                timed_out   <= 1'b1;
                err_timeout <= 1'b1;
            end
        end
    end
`else
    assign timed_out = 1'b0;
`endif

endmodule

// File: tb/tb_fftb_fifo_drain_scheduler.sv
// Testbench for fftb_fifo_drain_scheduler: behavioural FIFO sources, scoreboard on the stream side.
// Latency: n/a.
// Backpressure: out_ready driven steady or toggling per vector.
module tb_fftb_fifo_drain_scheduler;

    localparam int NS = 2;
    localparam int BL = 4;
    localparam int DW = 32;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable = 1'b0;
    logic              out_ready = 1'b1;
    logic [NS-1:0]     src_address, src_read, src_waitrequest;
    logic [NS*DW-1:0]  src_readdata;
    logic [DW-1:0]     out_data;
    logic              out_valid, out_sop, out_eop, busy, block_done;
    logic [2:0]        out_channel;
`ifdef FFTB_DRAIN_TIMEOUT_EN
    logic              err_timeout;
`endif

    always #5 clock = ~clock;

    fftb_fifo_drain_scheduler #(
        .NUM_SRC(NS), .BLOCK_LEN(BL), .DATA_W(DW)
`ifdef FFTB_DRAIN_TIMEOUT_EN
        , .TIMEOUT_CYC(8)
`endif
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .src_address(src_address), .src_read(src_read),
        .src_readdata(src_readdata), .src_waitrequest(src_waitrequest),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sop(out_sop), .out_eop(out_eop), .out_channel(out_channel),
        .busy(busy),
`ifdef FFTB_DRAIN_TIMEOUT_EN
        .err_timeout(err_timeout),
`endif
        .block_done(block_done)
    );

    // Non-showahead FIFO model: data appears the cycle after the read strobe.
    logic [DW-1:0] smem [NS][64];
    int            shead [NS];
    int            stail [NS] = '{0, 0};
    logic [DW-1:0] rdata [NS];

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NS; i++) begin
                shead[i] <= 0;
                rdata[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NS; i++)
                if (src_read[i] && shead[i] != stail[i]) begin
                    rdata[i] <= smem[i][shead[i]];
                    shead[i] <= shead[i] + 1;
                end
        end
    end

    assign src_readdata    = {rdata[1], rdata[0]};
    assign src_waitrequest = {shead[1] == stail[1], shead[0] == stail[0]};

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
        logic [2:0]    ch;
    } exp_t;

    exp_t exp_q [$];
    int   vectors = 0;
    int   miscompares = 0;
    int   reads_src [NS];
    int   reads_total = 0;
    int   pops = 0;
    int   blocks = 0;
    bit   ready_toggle = 1'b0;

    // Stream scoreboard and read-side protocol monitor.
    always @(negedge clock) begin
        if (reset_n) begin
            if ($countones(src_read) > 1) begin
                vectors++; miscompares++;
                $display("FAIL src_read_onehot: got %b required at most one bit", src_read);
            end
            for (int i = 0; i < NS; i++) begin
                if (src_read[i]) begin
                    vectors++;
                    if (src_waitrequest[i]) begin
                        miscompares++;
                        $display("FAIL read_while_empty: src %0d read with waitrequest=1", i);
                    end else if (reads_total - pops >= 2) begin
                        miscompares++;
                        $display("FAIL outstanding: read issued with %0d words outstanding, required < 2", reads_total - pops);
                    end
                    reads_src[i]++;
                    reads_total++;
                end
            end
            if (block_done) blocks++;
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_word: got data=%0h sop=%b eop=%b ch=%0d, required no word",
                             out_data, out_sop, out_eop, out_channel);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (out_data !== e.d || out_sop !== e.sop || out_eop !== e.eop || out_channel !== e.ch) begin
                        miscompares++;
                        $display("FAIL stream_word: got data=%0h sop=%b eop=%b ch=%0d, required data=%0h sop=%b eop=%b ch=%0d",
                                 out_data, out_sop, out_eop, out_channel, e.d, e.sop, e.eop, e.ch);
                    end
                end
                pops++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        out_ready = ready_toggle ? ~out_ready : 1'b1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        enable = 1'b0;
        ready_toggle = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        for (int i = 0; i < NS; i++) begin
            stail[i] = 0;
            reads_src[i] = 0;
        end
        reads_total = 0;
        pops = 0;
        blocks = 0;
        exp_q.delete();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic load_src(input int s, input int base, input int n);
        for (int k = 0; k < n; k++) begin
            smem[s][stail[s]] = DW'(base + k);
            stail[s] = stail[s] + 1;
        end
    endtask

    task automatic push_exp(input int d, input int idx, input int ch);
        exp_t e;
        e.d   = DW'(d);
        e.sop = (idx == 0);
        e.eop = (idx == BL - 1);
        e.ch  = 3'(ch);
        exp_q.push_back(e);
    endtask

    // Reference scheduler: all data is present before enable, so blocks follow plain round-robin.
    task automatic build_expected(input int n0, input int n1, input int b0, input int b1);
        int rem [NS];
        int off [NS];
        int base [NS];
        int p;
        int g;
        rem[0] = n0 / BL; rem[1] = n1 / BL;
        off[0] = 0; off[1] = 0;
        base[0] = b0; base[1] = b1;
        p = NS - 1;
        while (rem[0] + rem[1] > 0) begin
            g = -1;
            for (int k = 1; k <= NS; k++)
                if (g < 0 && rem[(p + k) % NS] > 0) g = (p + k) % NS;
            for (int j = 0; j < BL; j++) push_exp(base[g] + off[g] + j, j, g);
            off[g] += BL;
            rem[g]--;
            p = g;
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!(exp_q.size() == 0 && !busy) && n < budget) begin
            tick();
            n++;
        end
        if (!(exp_q.size() == 0 && !busy)) begin
            vectors++; miscompares++;
            $display("FAIL %s: timed out with %0d words pending", name, exp_q.size());
        end
    endtask

    task automatic wait_pops(input string name, input int target, input int budget);
        int n = 0;
        while (pops < target && n < budget) begin
            tick();
            n++;
        end
        if (pops < target) begin
            vectors++; miscompares++;
            $display("FAIL %s: got %0d words required %0d", name, pops, target);
        end
    endtask

    typedef struct {
        int n0, n1, b0, b1;
        bit tog;
        int exp_blocks, exp_rd0, exp_rd1;
    } vec_t;

    vec_t vt [5];

    initial begin
        vt[0] = '{n0: 4,  n1: 4, b0: 1,   b1: 11,  tog: 1'b0, exp_blocks: 2, exp_rd0: 4,  exp_rd1: 4};
        vt[1] = '{n0: 4,  n1: 4, b0: 1,   b1: 11,  tog: 1'b1, exp_blocks: 2, exp_rd0: 4,  exp_rd1: 4};
        vt[2] = '{n0: 0,  n1: 4, b0: 0,   b1: 21,  tog: 1'b0, exp_blocks: 1, exp_rd0: 0,  exp_rd1: 4};
        vt[3] = '{n0: 8,  n1: 8, b0: 100, b1: 200, tog: 1'b0, exp_blocks: 4, exp_rd0: 8,  exp_rd1: 8};
        vt[4] = '{n0: 12, n1: 4, b0: 300, b1: 400, tog: 1'b1, exp_blocks: 4, exp_rd0: 12, exp_rd1: 4};

        // Reset state, sampled while reset is held.
        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_src_read", src_read, 0);
        check("rst_busy", busy, 0);
        check("rst_block_done", block_done, 0);
        check("rst_sop_eop", {out_sop, out_eop}, 0);
        check("rst_channel", out_channel, 0);
`ifdef FFTB_DRAIN_TIMEOUT_EN
        check("rst_err_timeout", err_timeout, 0);
`endif

        for (int v = 0; v < 5; v++) begin
            do_reset();
            ready_toggle = vt[v].tog;
            load_src(0, vt[v].b0, vt[v].n0);
            load_src(1, vt[v].b1, vt[v].n1);
            build_expected(vt[v].n0, vt[v].n1, vt[v].b0, vt[v].b1);
            enable = 1'b1;
            wait_done("vec_drain", 400);
            enable = 1'b0;
            repeat (3) tick();
            check("vec_blocks", blocks, vt[v].exp_blocks);
            check("vec_reads_src0", reads_src[0], vt[v].exp_rd0);
            check("vec_reads_src1", reads_src[1], vt[v].exp_rd1);
            check("vec_idle_valid", out_valid, 0);
        end

        // Source runs dry mid-block: reads pause, then the block resumes.
        do_reset();
        load_src(0, 500, 2);
        for (int j = 0; j < BL; j++) push_exp(500 + j, j, 0);
        enable = 1'b1;
        repeat (12) tick();
        check("gap_reads_before", reads_src[0], 2);
        check("gap_words_before", pops, 2);
        repeat (20) tick();
        check("gap_reads_during", reads_src[0], 2);
        check("gap_valid_during", out_valid, 0);
        check("gap_busy_during", busy, 1);
        load_src(0, 502, 2);
        wait_done("gap_drain", 100);
        check("gap_blocks", blocks, 1);
        check("gap_reads_after", reads_src[0], 4);

        // enable dropped mid-block: block completes, nothing follows.
        do_reset();
        load_src(0, 600, 8);
        for (int j = 0; j < BL; j++) push_exp(600 + j, j, 0);
        enable = 1'b1;
        wait_pops("en_first_words", 2, 100);
        enable = 1'b0;
        check("en_busy_mid", busy, 1);
        wait_pops("en_last_word", 4, 100);
        check("en_busy_after_eop", busy, 0);
        check("en_blocks", blocks, 1);
        repeat (10) tick();
        check("en_reads_total", reads_src[0], 4);
        check("en_no_more_words", pops, 4);
        check("en_queue_empty", exp_q.size(), 0);

        // Reset mid-block: outputs clear immediately, partial packet abandoned.
        do_reset();
        load_src(0, 700, 8);
        for (int j = 0; j < BL; j++) push_exp(700 + j, j, 0);
        enable = 1'b1;
        wait_pops("rst_mid_words", 2, 100);
        reset_n = 1'b0;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_read", src_read, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_eop", out_eop, 0);
        check("rst_mid_done", block_done, 0);

`ifdef FFTB_DRAIN_TIMEOUT_EN
        // Starved source: packet zero-padded to full length, error flag sticky.
        do_reset();
        load_src(0, 800, 1);
        push_exp(800, 0, 0);
        for (int j = 1; j < BL; j++) push_exp(0, j, 0);
        enable = 1'b1;
        wait_done("to_drain", 200);
        check("to_blocks", blocks, 1);
        check("to_reads", reads_src[0], 1);
        check("to_err", err_timeout, 1);
        repeat (10) tick();
        check("to_err_sticky", err_timeout, 1);
        do_reset();
        check("to_err_cleared", err_timeout, 0);
`endif

        do_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
